// File: rtl/dm_mem_wb.sv
`default_nettype none
// ============================================================================
// Module   : dm_mem_wb
// Purpose  : M-stage data memory plus the M/W pipeline register.
//            Stores merge word / halfword / byte data into the addressed
//            32-bit word by byte lane. Loads always read the whole aligned
//            word. The raw word, the byte address and the load-type controls
//            are registered so the W stage can pick and extend the lane.
// Ports    : clk          - system clock, rising-edge active
//            reset_n      - synchronous reset, active-low
//            mem_write_M  - store enable
//            word_bit_M   - access size: 0 word, 1 half, 2 byte, 3 reserved
//            load_u_M     - unsigned-load flag (only pipelined)
//            AO_M         - byte address from the ALU
//            WD_M         - right-justified store data
//            align_err_M  - combinational misalignment / reserved-size flag
//            DR_W         - registered raw aligned word (read-old-data)
//            AO_W         - registered AO_M
//            word_bit_W   - registered word_bit_M
//            load_u_W     - registered load_u_M
// Revision : 1.0 - initial release
// ============================================================================
module dm_mem_wb #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_write_M,
  input  logic [1:0]  word_bit_M,
  input  logic        load_u_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] WD_M,
  output logic        align_err_M,
  output logic [31:0] DR_W,
  output logic [31:0] AO_W,
  output logic [1:0]  word_bit_W,
  output logic        load_u_W
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] c_SZ_WORD = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_BYTE = 2'd2;

  logic [31:0]           r_mem [c_DEPTH];
  logic [31:0]           r_dr_w;
  logic [31:0]           r_ao_w;
  logic [1:0]            r_word_bit_w;
  logic                  r_load_u_w;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_align_err;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_we;

  // Upper address bits are dropped, so addresses wrap around the array.
  assign w_idx = AO_M[ADDR_WIDTH+1:2];

  always_comb begin
    w_align_err = 1'b0;
    case (word_bit_M)
      c_SZ_WORD: w_align_err = (AO_M[1:0] != 2'b00);
      c_SZ_HALF: w_align_err = AO_M[0];
      c_SZ_BYTE: w_align_err = 1'b0;
      default:   w_align_err = 1'b1;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick the
  // lane(s) that actually get written.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WD_M;
    case (word_bit_M)
      c_SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = WD_M;
      end
      c_SZ_HALF: begin
        w_be    = AO_M[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD_M[15:0]}};
      end
      c_SZ_BYTE: begin
        w_be    = 4'b0001 << AO_M[1:0];
        w_wdata = {4{WD_M[7:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = WD_M;
      end
    endcase
  end

  assign w_we = mem_write_M & ~w_align_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_dr_w       <= '0;
      r_ao_w       <= '0;
      r_word_bit_w <= '0;
      r_load_u_w   <= 1'b0;
    end else begin
      // Non-blocking read of the same word gives read-old-data on a
      // same-cycle store.
      r_dr_w       <= r_mem[w_idx];
      r_ao_w       <= AO_M;
      r_word_bit_w <= word_bit_M;
      r_load_u_w   <= load_u_M;
      if (w_we) begin
        for (int k = 0; k < 4; k++) begin
          if (w_be[k]) begin
            r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  assign align_err_M = w_align_err;
  assign DR_W        = r_dr_w;
  assign AO_W        = r_ao_w;
  assign word_bit_W  = r_word_bit_w;
  assign load_u_W    = r_load_u_w;

endmodule
`default_nettype wire

// File: tb/tb_dm_mem_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_mem_wb
// Purpose  : Self-checking bench for dm_mem_wb. A byte-addressed reference
//            memory predicts every W-stage output; predictions are queued by
//            the driver and popped/compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_mem_wb;

  localparam int AW      = 10;
  localparam int C_BYTES = 4 * (1 << AW);

  typedef struct {
    logic [31:0] dr;
    logic [31:0] ao;
    logic [1:0]  wb;
    logic        lu;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_write_M;
  logic [1:0]  word_bit_M;
  logic        load_u_M;
  logic [31:0] AO_M;
  logic [31:0] WD_M;
  logic        align_err_M;
  logic [31:0] DR_W;
  logic [31:0] AO_W;
  logic [1:0]  word_bit_W;
  logic        load_u_W;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q[$];
  logic [7:0]  mb [C_BYTES];

  dm_mem_wb #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_write_M (mem_write_M),
    .word_bit_M  (word_bit_M),
    .load_u_M    (load_u_M),
    .AO_M        (AO_M),
    .WD_M        (WD_M),
    .align_err_M (align_err_M),
    .DR_W        (DR_W),
    .AO_W        (AO_W),
    .word_bit_W  (word_bit_W),
    .load_u_W    (load_u_W)
  );

  always #5 clk = ~clk;

  // Reference: byte-addressed little-endian memory, size in bytes.
  function automatic int size_of(input logic [1:0] wb);
    return (wb == 2'd0) ? 4 : (wb == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic model_err(input logic [1:0] wb, input logic [31:0] ao);
    if (wb == 2'd3) return 1'b1;
    return ((ao % size_of(wb)) != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] ao);
    int unsigned wa;
    wa = (ao % C_BYTES) & ~32'd3;
    return {mb[wa+3], mb[wa+2], mb[wa+1], mb[wa]};
  endfunction

  task automatic model_write(input logic [1:0] wb, input logic [31:0] ao,
                             input logic [31:0] wd);
    int unsigned ba;
    ba = ao % C_BYTES;
    for (int i = 0; i < size_of(wb); i++) mb[ba+i] = wd[8*i +: 8];
  endtask

  // One cycle of stimulus: drive at negedge, check the combinational flag,
  // queue the W-stage prediction, then update the reference memory.
  task automatic cyc(input logic rn, input logic we, input logic [1:0] wb,
                     input logic lu, input logic [31:0] ao, input logic [31:0] wd);
    exp_t  e;
    logic  err;
    @(negedge clk);
    reset_n = rn; mem_write_M = we; word_bit_M = wb;
    load_u_M = lu; AO_M = ao; WD_M = wd;
    #1;
    err = model_err(wb, ao);
    n_tests++;
    if (align_err_M !== err) begin
      n_fail++;
      $display("FAIL align_err ao=%h wb=%0d: got %b expected %b", ao, wb, align_err_M, err);
    end
    if (!rn) begin
      e = '{dr: 32'h0, ao: 32'h0, wb: 2'd0, lu: 1'b0};
      for (int i = 0; i < C_BYTES; i++) mb[i] = 8'h00;
    end else begin
      e = '{dr: model_read(ao), ao: ao, wb: wb, lu: lu};
      if (we && !err) model_write(wb, ao, wd);
    end
    exp_q.push_back(e);
  endtask

  task automatic sw(input logic [31:0] ao, input logic [31:0] wd);
    cyc(1'b1, 1'b1, 2'd0, 1'b0, ao, wd);
  endtask
  task automatic sh(input logic [31:0] ao, input logic [31:0] wd);
    cyc(1'b1, 1'b1, 2'd1, 1'b0, ao, wd);
  endtask
  task automatic sb(input logic [31:0] ao, input logic [31:0] wd);
    cyc(1'b1, 1'b1, 2'd2, 1'b0, ao, wd);
  endtask
  task automatic lw(input logic [31:0] ao);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, ao, 32'hDEAD_0000);
  endtask

  // Monitor: the register advances every cycle, so each edge presents one
  // output set matching the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (DR_W !== e.dr || AO_W !== e.ao || word_bit_W !== e.wb || load_u_W !== e.lu) begin
          n_fail++;
          $display("FAIL wstage: got DR=%h AO=%h wb=%0d lu=%b expected DR=%h AO=%h wb=%0d lu=%b",
                   DR_W, AO_W, word_bit_W, load_u_W, e.dr, e.ao, e.wb, e.lu);
        end
      end
    end
  end

  initial begin
    logic [31:0] ao;
    logic [1:0]  wb;
    int          budget;
    reset_n = 1'b0; mem_write_M = 1'b0; word_bit_M = 2'd0;
    load_u_M = 1'b0; AO_M = '0; WD_M = '0;

    // Reset, write idx 5, reset again (store during reset is lost), read.
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    sw(32'h14, 32'h5555_AAAA);
    cyc(1'b0, 1'b1, 2'd0, 1'b1, 32'h14, 32'h1234_0000);
    cyc(1'b0, 1'b1, 2'd0, 1'b0, 32'h18, 32'h9999_9999);
    lw(32'h14);
    lw(32'h18);

    // Word, then byte/halfword merge.
    sw(32'h20, 32'h1234_5678);
    lw(32'h20);
    sb(32'h21, 32'h0000_00AB);
    sh(32'h22, 32'h0000_CDEF);
    lw(32'h20);

    // Misaligned and reserved accesses must not write.
    sw(32'h40, 32'h0BAD_F00D);
    sw(32'h42, 32'hFFFF_FFFF);
    sh(32'h41, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 32'h40, 32'hFFFF_FFFF);
    sh(32'h43, 32'hFFFF_FFFF);
    sw(32'h41, 32'hFFFF_FFFF);
    lw(32'h40);

    // Read-old-data on same-cycle store.
    sw(32'h30, 32'h1111_1111);
    sw(32'h30, 32'hAAAA_5555);
    lw(32'h30);

    // Address wrap.
    sw((32'd4 << AW) + 32'h8, 32'hDEAD_BEEF);
    lw(32'h8);
    sb(32'hFFFF_F00B, 32'h0000_0042);
    lw(32'h8);

    // Random mix over a small window so stores are read back often.
    for (int n = 0; n < 600; n++) begin
      ao = $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) ao = ao | ($urandom() & 32'hFFFF_F000);
      wb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        cyc(1'b0, 1'($urandom_range(0, 1)), wb, 1'($urandom_range(0, 1)), ao, $urandom());
      else
        cyc(1'b1, 1'($urandom_range(0, 1)), wb, 1'($urandom_range(0, 1)), ao, $urandom());
    end

    // Idle one cycle so the last prediction gets consumed, then drain.
    lw(32'h0);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_mem_wb.md
Name: dm_mem_wb

Overview:
Data memory for the M stage plus the M/W pipeline register that feeds the W-stage load-extension logic.
- Performs word, halfword and byte stores with byte-lane merging.
- Reads the full aligned 32-bit word for loads.
- Registers the raw word together with the address and load-type controls, so the W stage can select and extend the lane one cycle later.

Parameters:
- ADDR_WIDTH, 10, word-address bits; the memory holds 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous reset, active-low.
- mem_write_M  input  1  store enable for the instruction in M.
- word_bit_M  input  2  access size: 0 = word, 1 = halfword, 2 = byte, 3 = reserved.
- load_u_M  input  1  unsigned-load flag; only pipelined, not used here.
- AO_M  input  32  byte address computed by the ALU.
- WD_M  input  32  store data, right-justified.
- align_err_M  output  1  combinational misalignment or reserved-size flag for the current M access.
- DR_W  output  32  registered raw aligned memory word.
- AO_W  output  32  registered AO_M.
- word_bit_W  output  2  registered word_bit_M.
- load_u_W  output  1  registered load_u_M.

Behaviour:
- Reset: on a rising edge with reset_n=0, every memory word is cleared to 0. DR_W, AO_W, word_bit_W and load_u_W are cleared to 0. No store occurs that cycle, even if mem_write_M=1.
- Indexing: word index = AO_M[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH bytes.
- Alignment, align_err_M = 1 when any of the following holds:
  - word_bit_M=0 and AO_M[1:0]≠0;
  - word_bit_M=1 and AO_M[0]=1;
  - word_bit_M=3.
  - Otherwise align_err_M = 0. It is purely combinational, independent of mem_write_M, and not gated by reset.
- Store, on a rising edge when reset_n=1, mem_write_M=1 and align_err_M=0:
  - word: mem[idx] <= WD_M.
  - halfword: AO_M[1]=0 writes WD_M[15:0] to bits 15:0; AO_M[1]=1 writes WD_M[15:0] to bits 31:16. The other half is unchanged.
  - byte: lane k = AO_M[1:0]; WD_M[7:0] is written to bits 8k+7:8k. The other three bytes are unchanged.
  - When align_err_M=1, the store is suppressed and memory is unchanged.
- Pipeline register, on every rising edge with reset_n=1:
  - DR_W <= mem[idx] as it was before this edge's store (read-old-data). This applies regardless of mem_write_M and align_err_M.
  - AO_W <= AO_M, word_bit_W <= word_bit_M, load_u_W <= load_u_M.
- Latency: a store is visible to a load issued in the next cycle. Load data appears on DR_W one cycle after the load is in M.
- No stall or flush input: the register advances every cycle.
- Reset asserted mid-sequence: a store presented in the same cycle is lost. The memory contents and the W outputs return to 0 on that edge.

Test Plan:
- Reset with reset_n=0 for 2 cycles, after writes to idx 5 → next cycle load of AO_M=0x14 gives DR_W=0x00000000; all W outputs are 0.
- sw WD=0x12345678 @0x20, next cycle lw @0x20 → DR_W=0x12345678, AO_W=0x20, word_bit_W=0.
- After the word above: sb WD=0xAB @0x21, then sh WD=0xCDEF @0x22, then lw @0x20 → DR_W=0xCDEFAB78.
- sw WD=0xFFFFFFFF @0x42 → align_err_M=1, memory unchanged; lw @0x40 gives the prior value. sh @0x41 and word_bit=3 @0x40 → align_err_M=1, no write.
- Same-cycle store and read: sw 0xAAAA5555 @0x30 while old mem=0x11111111 → DR_W next cycle = 0x11111111; a following lw @0x30 gives 0xAAAA5555.
- Wrap: sw 0xDEADBEEF @(4<<ADDR_WIDTH)+0x8 → lw @0x8 gives DR_W=0xDEADBEEF.
